sram_sp_be_burst_rd_ctrl: RTL and testbench
===========================================

// Module: sram_sp_be_burst_rd_ctrl
// PURPOSE
//  Port controller/client for a single-port, bit-write-enabled 192x64 SRAM
//  (e.g. ram_sp_be_192x64). Shares the one port between single-word masked writes
//  and burst reads. Burst-read data leaves on a valid/ready stream with backpressure.
//  Sits between the pipeline-stage write logic and the downstream fetch/consumer stage.
// PARAMETERS
//  DEPTH   192  number of SRAM words; read addresses wrap modulo DEPTH
//  ADR_WD  8    SRAM address width
//  DAT_WD  64   data width; also the bit-write-mask width
// PORTS
//  clk           in   1       clock; all logic on rising edge
//  rst           in   1       synchronous reset, active-high
//  wr_req_i      in   1       write request for this cycle
//  wr_adr_i      in   ADR_WD  write address (< DEPTH)
//  wr_msk_i      in   DAT_WD  per-bit write enable, 1 = write bit
//  wr_dat_i      in   DAT_WD  write data
//  wr_ack_o      out  1       write issued this cycle (combinational)
//  rd_start_i    in   1       burst start pulse
//  rd_base_i     in   ADR_WD  first burst address
//  rd_len_i      in   ADR_WD  burst length in words, 1..DEPTH
//  rd_busy_o     out  1       burst in progress (state != IDLE)
//  rd_err_o      out  1       1-cycle pulse: start rejected
//  rd_val_o      out  1       output word valid
//  rd_rdy_i      in   1       consumer ready
//  rd_dat_o      out  DAT_WD  output word
//  rd_last_o     out  1       qualifies the final word of the burst
//  mem_adr_o     out  ADR_WD  SRAM address
//  mem_wr_ena_o  out  DAT_WD  SRAM bit-write enable, high-active
//  mem_wr_dat_o  out  DAT_WD  SRAM write data
//  mem_rd_ena_o  out  1       SRAM op select: 1 = read, 0 = write
//  mem_rd_dat_i  in   DAT_WD  SRAM read data, valid 1 cycle after the read address
// BEHAVIOUR
//  Reset:
//   - Outputs: rd_busy_o = rd_err_o = rd_val_o = rd_last_o = 0; rd_dat_o = 0; wr_ack_o = 0.
//   - SRAM port: mem_rd_ena_o = 1, mem_wr_ena_o = 0, mem_adr_o = 0.
//   - State: FSM to IDLE; FIFO and in-flight flag cleared. A burst in progress is
//     abandoned with no further rd_val_o.
//  FSM IDLE -> READ:
//   - Taken on rd_start_i with 1 <= rd_len_i <= DEPTH and rd_base_i < DEPTH.
//   - Latches base and length; issue index = 0.
//   - Any other rd_start_i in IDLE is ignored and pulses rd_err_o.
//  FSM READ -> DRAIN: on issue of the last address (issue index = len-1).
//  FSM DRAIN -> IDLE: in the cycle the rd_last_o word is accepted (val & rdy).
//  rd_start_i in READ or DRAIN: ignored, pulses rd_err_o.
//  Port arbitration per cycle:
//   - Write wins. wr_ack_o = wr_req_i & ~rst.
//   - Write cycle: mem_rd_ena_o = 0; adr/msk/dat pass straight through.
//   - No write: mem_rd_ena_o = 1, mem_wr_ena_o = 0.
//  Read issue:
//   - Condition: state READ, no write, and credit: fifo_cnt + inflight - pop < 2
//     (2-entry FIFO).
//   - Issued address: (base + idx) wraps DEPTH-1 -> 0 (not 2^ADR_WD).
//  Capture:
//   - mem_rd_dat_i is pushed into the FIFO the cycle after an issue.
//   - The FIFO carries a last flag with the data.
//  Output:
//   - rd_val_o/rd_dat_o/rd_last_o come from the FIFO head.
//   - Data is held stable while rd_val_o & ~rd_rdy_i.
//   - Simultaneous push and pop is allowed.
//  Latency: start accepted at edge T -> first address issued in cycle T+1 ->
//   rd_val_o in cycle T+3.
//  Throughput: 1 word/cycle with rdy held high and no writes.
//  Ordering: a write to a not-yet-issued burst address is returned by the burst;
//   a write to an already-issued address is not.
//  Idle SRAM reads are unqualified and never reach the FIFO.
// TESTING
//  1. Reset for 2 cycles -> mem_rd_ena_o = 1, mem_wr_ena_o = 0, rd_val_o = 0,
//     rd_busy_o = 0.
//  2. Preload word[k] = k, then start base=10 len=4 with rdy = 1 ->
//     data 10,11,12,13 in cycles T+3..T+6; rd_last_o only with 13; IDLE at T+6.
//  3. base=190 len=4 -> issued addresses 190,191,0,1; data in that order.
//  4. len=8 with rd_rdy_i low for 6 cycles after the first valid ->
//     at most 2 words buffered; no loss or duplicate; rd_dat_o stable while stalled.
//  5. Mid-burst write to adr 14, msk = 0x00FF, dat = 0xAB ->
//     wr_ack_o = 1 that cycle; read issue stalls one cycle;
//     word 14 returned as (old & ~0xFF) | 0xAB.
//  6. rst during burst -> next cycle rd_val_o = 0 and IDLE.
//     Starts with len=0, len=193, or base=200, or any start while busy ->
//     rd_err_o pulses for 1 cycle; state unchanged.

Source files
------------

// File: rtl/sram_sp_be_burst_rd_ctrl.sv
// ---------------------------------------------------------------------------
// sram_sp_be_burst_rd_ctrl
//
// Port controller for a single-port, bit-write-enabled SRAM (e.g. a 192x64
// ram_sp_be). Single-word masked writes and burst reads share the one SRAM
// port. Writes always take priority. A burst reads rd_len_i consecutive
// words starting at rd_base_i, wrapping at DEPTH-1 back to 0. Burst data
// leaves on a valid/ready stream through a 2-entry skid FIFO, so
// backpressure never loses a word that was already read from the SRAM.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   wr_req_i        write request (always accepted unless in reset)
//   wr_adr_i        write address
//   wr_msk_i        per-bit write enable
//   wr_dat_i        write data
//   wr_ack_o        write issued this cycle (combinational)
//   rd_start_i      burst start pulse
//   rd_base_i       first burst address
//   rd_len_i        burst length in words, 1..DEPTH
//   rd_busy_o       burst in progress
//   rd_err_o        one-cycle pulse: a start request was rejected
//   rd_val_o        output word valid
//   rd_rdy_i        consumer ready
//   rd_dat_o        output word (0 while no word is valid)
//   rd_last_o       final word of the burst
//   mem_adr_o       SRAM address
//   mem_wr_ena_o    SRAM bit-write enable
//   mem_wr_dat_o    SRAM write data
//   mem_rd_ena_o    SRAM op select: 1 = read, 0 = write
//   mem_rd_dat_i    SRAM read data, one cycle after the read address
// ---------------------------------------------------------------------------
module sram_sp_be_burst_rd_ctrl #(
    parameter int DEPTH  = 192,
    parameter int ADR_WD = 8,
    parameter int DAT_WD = 64
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              wr_req_i,
    input  logic [ADR_WD-1:0] wr_adr_i,
    input  logic [DAT_WD-1:0] wr_msk_i,
    input  logic [DAT_WD-1:0] wr_dat_i,
    output logic              wr_ack_o,

    input  logic              rd_start_i,
    input  logic [ADR_WD-1:0] rd_base_i,
    input  logic [ADR_WD-1:0] rd_len_i,
    output logic              rd_busy_o,
    output logic              rd_err_o,
    output logic              rd_val_o,
    input  logic              rd_rdy_i,
    output logic [DAT_WD-1:0] rd_dat_o,
    output logic              rd_last_o,

    output logic [ADR_WD-1:0] mem_adr_o,
    output logic [DAT_WD-1:0] mem_wr_ena_o,
    output logic [DAT_WD-1:0] mem_wr_dat_o,
    output logic              mem_rd_ena_o,
    input  logic [DAT_WD-1:0] mem_rd_dat_i
);

    localparam logic [ADR_WD:0]   DEPTH_W  = (ADR_WD+1)'(DEPTH);
    localparam logic [ADR_WD-1:0] LAST_ADR = ADR_WD'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Address increment that wraps at the last SRAM word rather than at 2^ADR_WD.
    function automatic logic [ADR_WD-1:0] wrap_inc(input logic [ADR_WD-1:0] a);
        logic [ADR_WD-1:0] r;
        if (a == LAST_ADR) begin
            r = '0;
        end else begin
            r = a + ADR_WD'(1);
        end
        return r;
    endfunction

    state_t            state_q;
    state_t            state_d;

    logic [ADR_WD-1:0] cur_adr_q;   // next burst address to issue
    logic [ADR_WD-1:0] idx_q;       // issue index within the burst
    logic [ADR_WD-1:0] len_q;
    logic              rd_err_q;

    logic              start_ok;
    logic              accept;
    logic              wr_go;
    logic              credit;
    logic              last_issue;
    logic [2:0]        occ_after;

    logic              vld_p0;
    logic              last_p0;
    logic              vld_p1;
    logic              last_p1;

    logic [DAT_WD-1:0] fifo_dat [2];
    logic              fifo_last [2];
    logic              fifo_wr_ptr;
    logic              fifo_rd_ptr;
    logic [1:0]        fifo_cnt;
    logic              push;
    logic              pop;

    assign start_ok = ({1'b0, rd_len_i} != '0) &&
                      ({1'b0, rd_len_i} <= DEPTH_W) &&
                      ({1'b0, rd_base_i} < DEPTH_W);
    assign accept   = (state_q == IDLE) && rd_start_i && start_ok;

    assign wr_go    = wr_req_i & ~rst;
    assign wr_ack_o = wr_go;

    assign rd_val_o  = (fifo_cnt != 2'd0);
    assign rd_dat_o  = rd_val_o ? fifo_dat[fifo_rd_ptr] : '0;
    assign rd_last_o = rd_val_o & fifo_last[fifo_rd_ptr];
    assign rd_busy_o = (state_q != IDLE);
    assign rd_err_o  = rd_err_q;

    assign pop  = rd_val_o & rd_rdy_i;
    assign push = vld_p1;

    // A read may only be issued when the FIFO is guaranteed to have a slot
    // for it once the data returns: entries held + word in flight - word
    // leaving this cycle must stay below the FIFO depth of 2.
    assign occ_after  = {1'b0, fifo_cnt} + {2'b00, vld_p1} - {2'b00, pop};
    assign credit     = (occ_after < 3'd2);
    assign last_issue = (idx_q == (len_q - ADR_WD'(1)));

    // Stage p0: read issue onto the SRAM port
    assign vld_p0  = (state_q == READ) && !wr_req_i && credit && !rst;
    assign last_p0 = vld_p0 && last_issue;

    always_comb begin
        mem_adr_o    = '0;
        mem_wr_ena_o = '0;
        mem_wr_dat_o = '0;
        mem_rd_ena_o = 1'b1;
        if (wr_go) begin
            mem_adr_o    = wr_adr_i;
            mem_wr_ena_o = wr_msk_i;
            mem_wr_dat_o = wr_dat_i;
            mem_rd_ena_o = 1'b0;
        end else if ((state_q == READ) && !rst) begin
            // Stalled cycles still present the pending address; such reads
            // are unqualified and never reach the FIFO.
            mem_adr_o = cur_adr_q;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = READ;
                end
            end
            READ: begin
                if (last_p0) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && rd_last_o) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cur_adr_q <= '0;
            idx_q     <= '0;
            len_q     <= '0;
            rd_err_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_err_q <= rd_start_i && !accept;
            if (accept) begin
                cur_adr_q <= rd_base_i;
                idx_q     <= '0;
                len_q     <= rd_len_i;
            end else if (vld_p0) begin
                cur_adr_q <= wrap_inc(cur_adr_q);
                idx_q     <= idx_q + ADR_WD'(1);
            end
        end
    end

    // Stage p1: SRAM read in flight, data returns on mem_rd_dat_i
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
        end else begin
            vld_p1  <= vld_p0;
            last_p1 <= last_p0;
        end
    end

    // Stage p2: capture into the output FIFO
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_dat[fifo_wr_ptr]  <= mem_rd_dat_i;
            fifo_last[fifo_wr_ptr] <= last_p1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_wr_ptr <= 1'b0;
            fifo_rd_ptr <= 1'b0;
            fifo_cnt    <= 2'd0;
        end else begin
            if (push) begin
                fifo_wr_ptr <= ~fifo_wr_ptr;
            end
            if (pop) begin
                fifo_rd_ptr <= ~fifo_rd_ptr;
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
                2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_sp_be_burst_rd_ctrl.sv
module tb_sram_sp_be_burst_rd_ctrl;

    localparam int DEPTH  = 192;
    localparam int ADR_WD = 8;
    localparam int DAT_WD = 64;

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_req_i;
    logic [ADR_WD-1:0] wr_adr_i;
    logic [DAT_WD-1:0] wr_msk_i;
    logic [DAT_WD-1:0] wr_dat_i;
    logic              wr_ack_o;
    logic              rd_start_i;
    logic [ADR_WD-1:0] rd_base_i;
    logic [ADR_WD-1:0] rd_len_i;
    logic              rd_busy_o;
    logic              rd_err_o;
    logic              rd_val_o;
    logic              rd_rdy_i;
    logic [DAT_WD-1:0] rd_dat_o;
    logic              rd_last_o;
    logic [ADR_WD-1:0] mem_adr_o;
    logic [DAT_WD-1:0] mem_wr_ena_o;
    logic [DAT_WD-1:0] mem_wr_dat_o;
    logic              mem_rd_ena_o;
    logic [DAT_WD-1:0] mem_rd_dat_i;

    always #5 clk = ~clk;

    sram_sp_be_burst_rd_ctrl #(.DEPTH(DEPTH), .ADR_WD(ADR_WD), .DAT_WD(DAT_WD)) dut (
        .clk(clk), .rst(rst),
        .wr_req_i(wr_req_i), .wr_adr_i(wr_adr_i), .wr_msk_i(wr_msk_i),
        .wr_dat_i(wr_dat_i), .wr_ack_o(wr_ack_o),
        .rd_start_i(rd_start_i), .rd_base_i(rd_base_i), .rd_len_i(rd_len_i),
        .rd_busy_o(rd_busy_o), .rd_err_o(rd_err_o), .rd_val_o(rd_val_o),
        .rd_rdy_i(rd_rdy_i), .rd_dat_o(rd_dat_o), .rd_last_o(rd_last_o),
        .mem_adr_o(mem_adr_o), .mem_wr_ena_o(mem_wr_ena_o),
        .mem_wr_dat_o(mem_wr_dat_o), .mem_rd_ena_o(mem_rd_ena_o),
        .mem_rd_dat_i(mem_rd_dat_i)
    );

    // Behavioural single-port SRAM with per-bit write enable, 1-cycle read.
    logic [DAT_WD-1:0] sram [0:255];
    always @(posedge clk) begin
        if (mem_rd_ena_o) begin
            mem_rd_dat_i <= sram[mem_adr_o];
        end else begin
            sram[mem_adr_o] <= (sram[mem_adr_o] & ~mem_wr_ena_o) | (mem_wr_dat_o & mem_wr_ena_o);
        end
    end

    // Reference memory contents as seen by the controller's clients.
    logic [DAT_WD-1:0] ref_mem [0:DEPTH-1];

    typedef struct packed {
        logic [DAT_WD-1:0] d;
        logic              l;
    } exp_t;
    exp_t exp_q[$];

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic void ref_apply(input int a, input logic [DAT_WD-1:0] m, input logic [DAT_WD-1:0] d);
        ref_mem[a] = (ref_mem[a] & ~m) | (d & m);
    endfunction

    function automatic bit in_burst(input int a, input int b, input int l);
        int off;
        off = (a - b + DEPTH) % DEPTH;
        return off < l;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input int a, input logic [DAT_WD-1:0] m, input logic [DAT_WD-1:0] d);
        ref_apply(a, m, d);
        wr_req_i = 1'b1;
        wr_adr_i = ADR_WD'(a);
        wr_msk_i = m;
        wr_dat_i = d;
        tick();
        wr_req_i = 1'b0;
    endtask

    // Pushes the expected words for the burst, then issues the start pulse.
    // Returns 1 ns after the accepting edge.
    task automatic start_burst(input int b, input int l);
        for (int i = 0; i < l; i++) begin
            exp_t e;
            e.d = ref_mem[(b + i) % DEPTH];
            e.l = (i == l - 1);
            exp_q.push_back(e);
        end
        rd_start_i = 1'b1;
        rd_base_i  = ADR_WD'(b);
        rd_len_i   = ADR_WD'(l);
        tick();
        rd_start_i = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int c;
        c = 0;
        while (rd_busy_o && c < bound) begin
            @(negedge clk);
            c++;
        end
        chk("burst_done", rd_busy_o, 0);
        tick();
    endtask

    task automatic bad_start(input int b, input int l, input logic exp_busy);
        rd_start_i = 1'b1;
        rd_base_i  = ADR_WD'(b);
        rd_len_i   = ADR_WD'(l);
        tick();
        rd_start_i = 1'b0;
        @(negedge clk);
        chk("err_pulse", rd_err_o, 1);
        chk("err_busy", rd_busy_o, 64'(exp_busy));
        tick();
        @(negedge clk);
        chk("err_clear", rd_err_o, 0);
        tick();
    endtask

    // Scoreboard monitor: compares every accepted word and checks that a
    // stalled word stays stable until it is taken.
    initial begin
        logic              prev_stall;
        logic [DAT_WD-1:0] prev_dat;
        logic              prev_last;
        exp_t              e;
        prev_stall = 1'b0;
        prev_dat   = '0;
        prev_last  = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    chk("stall_val", rd_val_o, 1);
                    chk("stall_dat", rd_dat_o, prev_dat);
                    chk("stall_last", rd_last_o, 64'(prev_last));
                end
                if (rd_val_o && rd_rdy_i) begin
                    if (exp_q.size() == 0) begin
                        n_tot++;
                        $display("FAIL unexpected_word: got %h expected none", rd_dat_o);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rd_dat", rd_dat_o, e.d);
                        chk("rd_last", rd_last_o, 64'(e.l));
                    end
                end
                prev_stall = rd_val_o & ~rd_rdy_i;
                prev_dat   = rd_dat_o;
                prev_last  = rd_last_o;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int b;
        int l;
        int a;
        rst        = 1'b1;
        wr_req_i   = 1'b0;
        wr_adr_i   = '0;
        wr_msk_i   = '0;
        wr_dat_i   = '0;
        rd_start_i = 1'b0;
        rd_base_i  = '0;
        rd_len_i   = '0;
        rd_rdy_i   = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mem_rd_ena", mem_rd_ena_o, 1);
        chk("rst_mem_wr_ena", mem_wr_ena_o, 0);
        chk("rst_mem_adr", mem_adr_o, 0);
        chk("rst_rd_val", rd_val_o, 0);
        chk("rst_rd_busy", rd_busy_o, 0);
        chk("rst_rd_dat", rd_dat_o, 0);
        chk("rst_wr_ack", wr_ack_o, 0);
        chk("rst_rd_err", rd_err_o, 0);
        tick();

        for (int k = 0; k < DEPTH; k++) do_write(k, '1, 64'(k));

        // Latency, order and last flag for base=10 len=4
        start_burst(10, 4);
        for (int n = 1; n <= 7; n++) begin
            @(negedge clk);
            if (n == 1) chk("lat_busy", rd_busy_o, 1);
            if (n <= 2) chk("lat_noval", rd_val_o, 0);
            if (n == 3) chk("lat_first_val", rd_val_o, 1);
            if (n == 4) chk("last_early", rd_last_o, 0);
            if (n == 6) chk("last_flag", rd_last_o, 1);
            if (n == 7) chk("idle_after_last", rd_busy_o, 0);
        end
        tick();

        // Address wrap at DEPTH-1
        start_burst(190, 4);
        for (int n = 1; n <= 4; n++) begin
            @(negedge clk);
            chk("wrap_adr", mem_adr_o, 64'((190 + n - 1) % DEPTH));
        end
        tick();
        wait_idle(50);

        // Backpressure: consumer stalled while the first word is presented
        rd_rdy_i = 1'b0;
        start_burst(40, 8);
        repeat (7) tick();
        @(negedge clk);
        chk("stall_issue_held", mem_adr_o, 42);
        chk("stall_busy", rd_busy_o, 1);
        tick();
        rd_rdy_i = 1'b1;
        wait_idle(100);

        // Mid-burst masked write to a not-yet-issued address
        do_write(14, '1, 64'hFEDC_BA98_7654_3210);
        ref_apply(14, 64'h00FF, 64'h00AB);
        start_burst(10, 8);
        wr_req_i = 1'b1;
        wr_adr_i = 8'd14;
        wr_msk_i = 64'h00FF;
        wr_dat_i = 64'h00AB;
        @(negedge clk);
        chk("mid_wr_ack", wr_ack_o, 1);
        chk("mid_wr_rd_ena", mem_rd_ena_o, 0);
        chk("mid_wr_ena", mem_wr_ena_o, 64'h00FF);
        chk("mid_wr_adr", mem_adr_o, 14);
        tick();
        wr_req_i = 1'b0;
        @(negedge clk);
        chk("issue_after_wr_adr", mem_adr_o, 10);
        chk("issue_after_wr_rd", mem_rd_ena_o, 1);
        tick();
        wait_idle(100);

        // Reset during a burst
        start_burst(60, 8);
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_burst_val", rd_val_o, 0);
        chk("rst_burst_busy", rd_busy_o, 0);
        chk("rst_burst_dat", rd_dat_o, 0);
        tick();

        // Rejected starts
        bad_start(0, 0, 1'b0);
        bad_start(0, 193, 1'b0);
        bad_start(200, 4, 1'b0);
        start_burst(20, 6);
        bad_start(100, 3, 1'b1);
        wait_idle(100);

        // Randomized bursts with random backpressure and non-conflicting writes
        for (int k = 0; k < DEPTH; k++) do_write(k, '1, {$urandom, $urandom});
        for (int r = 0; r < 20; r++) begin
            int c;
            b = int'($urandom_range(0, DEPTH - 1));
            l = (r == 10) ? DEPTH : int'($urandom_range(1, 24));
            start_burst(b, l);
            c = 0;
            while (rd_busy_o && c < 3000) begin
                rd_rdy_i = ($urandom % 4) != 0;
                wr_req_i = 1'b0;
                if (($urandom % 5) == 0) begin
                    a = int'($urandom_range(0, DEPTH - 1));
                    if (!in_burst(a, b, l)) begin
                        wr_msk_i = {$urandom, $urandom};
                        wr_dat_i = {$urandom, $urandom};
                        wr_adr_i = ADR_WD'(a);
                        wr_req_i = 1'b1;
                        ref_apply(a, wr_msk_i, wr_dat_i);
                    end
                end
                tick();
                c++;
            end
            wr_req_i = 1'b0;
            rd_rdy_i = 1'b1;
            chk("rand_burst_done", rd_busy_o, 0);
            tick();
        end

        repeat (4) tick();
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
